// File: rtl/lfsr_draw_arbiter_if.sv
// Request/grant/result bundle between the requesters and the shared LFSR draw arbiter.
// The master side drives requests and limits, the slave side (the arbiter) answers.
interface lfsr_draw_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [3*N_REQ-1:0] limit;
    logic [N_REQ-1:0]   gnt;
    logic [2:0]         rnd_out;
    logic               rnd_valid;
    logic               rnd_fail;
    logic               busy;

    modport master (
        output req, limit,
        input  gnt, rnd_out, rnd_valid, rnd_fail, busy
    );

    modport slave (
        input  req, limit,
        output gnt, rnd_out, rnd_valid, rnd_fail, busy
    );
endinterface

// File: rtl/lfsr_draw_arbiter.sv
// Round-robin arbiter sharing one 3-bit XNOR LFSR among requesters; rejection-samples
// values against the granted requester's limit and gives up after MAX_TRIES draws.
module lfsr_draw_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_TRIES = 7
) (
    input logic             clk,
    input logic             reset,
    lfsr_draw_arbiter_if.slave bus
);
    localparam int SW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t          state, state_n;
    logic [2:0]      lfsr, lfsr_n;
    logic [2:0]      lim, lim_n;
    logic [2:0]      rnd_out_q, rnd_out_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic            valid_q, valid_n;
    logic            fail_q, fail_n;
    logic [3:0]      tries, tries_n;
    logic [SW-1:0]   rr_ptr, rr_ptr_n;
    logic [SW-1:0]   sel, sel_n;
    logic [SW-1:0]   pick, idx;
    logic [2:0]      pick_lim;
    logic            found;

    // 111 is the XNOR lockup state; steer it back into the period-7 cycle.
    function automatic logic [2:0] lfsr_step(input logic [2:0] v);
        if (v == 3'b111)
            return 3'b000;
        return {v[1:0], ~(v[1] ^ v[2])};
    endfunction

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] i);
        if (int'(i) == N_REQ - 1)
            return '0;
        return i + 1'b1;
    endfunction

    // First active request at or after rr_ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        pick     = rr_ptr;
        idx      = '0;
        pick_lim = 3'b000;
        for (int k = 0; k < N_REQ; k++) begin
            idx = SW'((int'(rr_ptr) + k) % N_REQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (int'(pick) == k)
                pick_lim = bus.limit[3*k +: 3];
        end
    end

    always_comb begin
        state_n   = state;
        lfsr_n    = lfsr;
        lim_n     = lim;
        rnd_out_n = rnd_out_q;
        gnt_n     = gnt_q;
        valid_n   = 1'b0;
        fail_n    = 1'b0;
        tries_n   = tries;
        rr_ptr_n  = rr_ptr;
        sel_n     = sel;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (found) begin
                    gnt_n   = N_REQ'(1) << pick;
                    sel_n   = pick;
                    lim_n   = pick_lim;
                    tries_n = 4'd0;
                    state_n = DRAW;
                end
            end
            DRAW: begin
                lfsr_n = lfsr_step(lfsr);
                // Accept is checked before the try budget so the last draw can still succeed.
                if (!bus.req[sel]) begin
                    gnt_n    = '0;
                    rr_ptr_n = wrap_inc(sel);
                    state_n  = IDLE;
                end else if (lfsr <= lim) begin
                    rnd_out_n = lfsr;
                    valid_n   = 1'b1;
                    state_n   = DONE;
                end else if (tries == 4'(MAX_TRIES - 1)) begin
                    fail_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    tries_n = tries + 4'd1;
                end
            end
            DONE: begin
                gnt_n    = '0;
                rr_ptr_n = wrap_inc(sel);
                state_n  = IDLE;
            end
            default: begin
                gnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            lfsr      <= 3'b000;
            lim       <= 3'b000;
            rnd_out_q <= 3'b000;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            fail_q    <= 1'b0;
            tries     <= 4'd0;
            rr_ptr    <= '0;
            sel       <= '0;
        end else begin
            state     <= state_n;
            lfsr      <= lfsr_n;
            lim       <= lim_n;
            rnd_out_q <= rnd_out_n;
            gnt_q     <= gnt_n;
            valid_q   <= valid_n;
            fail_q    <= fail_n;
            tries     <= tries_n;
            rr_ptr    <= rr_ptr_n;
            sel       <= sel_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_out   = rnd_out_q;
    assign bus.rnd_valid = valid_q;
    assign bus.rnd_fail  = fail_q;
    assign bus.busy      = (state == DRAW) || (state == DONE);
endmodule

// File: tb/tb_lfsr_draw_arbiter.sv
// Directed bench for lfsr_draw_arbiter: a default build (MAX_TRIES=7) and a MAX_TRIES=3
// build share clock and reset; expected values are hand-derived from the LFSR sequence.
module tb_lfsr_draw_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    lfsr_draw_arbiter_if #(.N_REQ(4)) ifa ();
    lfsr_draw_arbiter_if #(.N_REQ(4)) ifb ();

    lfsr_draw_arbiter #(.N_REQ(4), .MAX_TRIES(7)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    lfsr_draw_arbiter #(.N_REQ(4), .MAX_TRIES(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ifa.req = '0; ifa.limit = '0;
        ifb.req = '0; ifb.limit = '0;
        repeat (3) tick();
        n_cmp++; if (ifa.gnt !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_gnt: got %b want 0000", ifa.gnt); end
        n_cmp++; if (ifa.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", ifa.busy); end
        n_cmp++; if (ifa.rnd_out !== 3'b000) begin n_bad++; $display("[TB] FAIL reset_rnd_out: got %b want 000", ifa.rnd_out); end
        n_cmp++; if (ifa.rnd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", ifa.rnd_valid); end
        n_cmp++; if (ifa.rnd_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_fail: got %b want 0", ifa.rnd_fail); end
        n_cmp++; if (ifb.gnt !== 4'b0000) begin n_bad++; $display("[TB] FAIL reset_gnt_b: got %b want 0000", ifb.gnt); end
        reset = 1'b1;
    endtask

    task automatic test_first_draw;
        ifa.limit = 12'hFFF;
        ifa.req   = 4'b0001;
        tick();
        n_cmp++; if (ifa.gnt !== 4'b0001) begin n_bad++; $display("[TB] FAIL first_gnt: got %b want 0001", ifa.gnt); end
        n_cmp++; if (ifa.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL first_busy: got %b want 1", ifa.busy); end
        n_cmp++; if (ifa.rnd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL first_early_valid: got %b want 0", ifa.rnd_valid); end
        tick();
        n_cmp++; if (ifa.rnd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL first_valid: got %b want 1", ifa.rnd_valid); end
        n_cmp++; if (ifa.rnd_out !== 3'b000) begin n_bad++; $display("[TB] FAIL first_rnd_out: got %b want 000", ifa.rnd_out); end
        n_cmp++; if (ifa.gnt !== 4'b0001) begin n_bad++; $display("[TB] FAIL first_done_gnt: got %b want 0001", ifa.gnt); end
        ifa.req = 4'b0000;
        tick();
        n_cmp++; if (ifa.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL first_idle_busy: got %b want 0", ifa.busy); end
        n_cmp++; if (ifa.gnt !== 4'b0000) begin n_bad++; $display("[TB] FAIL first_idle_gnt: got %b want 0000", ifa.gnt); end
        n_cmp++; if (ifa.rnd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL first_valid_pulse: got %b want 0", ifa.rnd_valid); end
    endtask

    task automatic test_last_try_accept;
        int cycles;
        logic saw_fail;
        cycles = 0;
        saw_fail = 1'b0;
        ifa.limit = 12'hFC7;
        ifa.req   = 4'b0010;
        tick();
        n_cmp++; if (ifa.gnt !== 4'b0010) begin n_bad++; $display("[TB] FAIL last_gnt: got %b want 0010", ifa.gnt); end
        while (ifa.rnd_valid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
            if (ifa.rnd_fail === 1'b1) saw_fail = 1'b1;
        end
        n_cmp++; if (cycles != 7) begin n_bad++; $display("[TB] FAIL last_draw_cycles: got %0d want 7", cycles); end
        n_cmp++; if (ifa.rnd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL last_valid: got %b want 1", ifa.rnd_valid); end
        n_cmp++; if (ifa.rnd_out !== 3'b000) begin n_bad++; $display("[TB] FAIL last_rnd_out: got %b want 000", ifa.rnd_out); end
        n_cmp++; if (saw_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL last_no_fail: got %b want 0", saw_fail); end
        ifa.req = 4'b0000;
        tick();
        n_cmp++; if (ifa.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL last_idle_busy: got %b want 0", ifa.busy); end
    endtask

    task automatic test_fail_max_tries;
        int cycles;
        cycles = 0;
        ifb.limit = 12'hFFF;
        ifb.req   = 4'b0001;
        tick();
        tick();
        n_cmp++; if (ifb.rnd_valid !== 1'b1 || ifb.rnd_out !== 3'b000) begin n_bad++; $display("[TB] FAIL mt3_warmup: got valid=%b out=%b want valid=1 out=000", ifb.rnd_valid, ifb.rnd_out); end
        ifb.req = 4'b0000;
        tick();
        ifb.limit = 12'hFF8;
        ifb.req   = 4'b0001;
        tick();
        n_cmp++; if (ifb.gnt !== 4'b0001) begin n_bad++; $display("[TB] FAIL mt3_gnt: got %b want 0001", ifb.gnt); end
        while (ifb.rnd_fail !== 1'b1 && ifb.rnd_valid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        n_cmp++; if (cycles != 3) begin n_bad++; $display("[TB] FAIL mt3_cycles: got %0d want 3", cycles); end
        n_cmp++; if (ifb.rnd_fail !== 1'b1) begin n_bad++; $display("[TB] FAIL mt3_fail: got %b want 1", ifb.rnd_fail); end
        n_cmp++; if (ifb.rnd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mt3_valid: got %b want 0", ifb.rnd_valid); end
        n_cmp++; if (ifb.rnd_out !== 3'b000) begin n_bad++; $display("[TB] FAIL mt3_rnd_out_held: got %b want 000", ifb.rnd_out); end
        n_cmp++; if (ifb.gnt !== 4'b0001) begin n_bad++; $display("[TB] FAIL mt3_done_gnt: got %b want 0001", ifb.gnt); end
        ifb.req = 4'b0000;
        tick();
        n_cmp++; if (ifb.rnd_fail !== 1'b0 || ifb.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mt3_idle: got fail=%b busy=%b want 0 0", ifb.rnd_fail, ifb.busy); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_gnt [5];
        logic [2:0] exp_out [5];
        int cycles;
        int multi;
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_out = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101};
        multi = 0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        ifa.limit = 12'hFFF;
        ifa.req   = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            cycles = 0;
            do begin
                tick();
                cycles++;
                if ($countones(ifa.gnt) > 1) multi++;
            end while (ifa.gnt === 4'b0000 && cycles < 6);
            n_cmp++; if (ifa.gnt !== exp_gnt[s]) begin n_bad++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", s, ifa.gnt, exp_gnt[s]); end
            n_cmp++; if (cycles != 1) begin n_bad++; $display("[TB] FAIL rr_idle_gap[%0d]: got %0d want 1", s, cycles); end
            tick();
            if ($countones(ifa.gnt) > 1) multi++;
            n_cmp++; if (ifa.rnd_valid !== 1'b1 || ifa.rnd_out !== exp_out[s]) begin n_bad++; $display("[TB] FAIL rr_out[%0d]: got valid=%b out=%b want valid=1 out=%b", s, ifa.rnd_valid, ifa.rnd_out, exp_out[s]); end
            tick();
            n_cmp++; if (ifa.gnt !== 4'b0000 || ifa.rnd_out !== exp_out[s]) begin n_bad++; $display("[TB] FAIL rr_idle[%0d]: got gnt=%b out=%b want gnt=0000 out=%b", s, ifa.gnt, ifa.rnd_out, exp_out[s]); end
        end
        n_cmp++; if (multi != 0) begin n_bad++; $display("[TB] FAIL rr_onehot: got %0d multi-hot samples want 0", multi); end
        ifa.req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_draw;
        ifa.limit = 12'h000;
        ifa.req   = 4'b0010;
        tick();
        n_cmp++; if (ifa.gnt !== 4'b0010) begin n_bad++; $display("[TB] FAIL mid_gnt: got %b want 0010", ifa.gnt); end
        tick();
        tick();
        n_cmp++; if (ifa.busy !== 1'b1 || ifa.rnd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_drawing: got busy=%b valid=%b want 1 0", ifa.busy, ifa.rnd_valid); end
        reset   = 1'b0;
        ifa.req = 4'b0000;
        tick();
        n_cmp++; if (ifa.gnt !== 4'b0000 || ifa.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_reset_state: got gnt=%b busy=%b want 0000 0", ifa.gnt, ifa.busy); end
        n_cmp++; if (ifa.rnd_valid !== 1'b0 || ifa.rnd_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_reset_pulse: got valid=%b fail=%b want 0 0", ifa.rnd_valid, ifa.rnd_fail); end
        reset = 1'b1;
        tick();
        n_cmp++; if (ifa.rnd_valid !== 1'b0 || ifa.rnd_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_after_pulse: got valid=%b fail=%b want 0 0", ifa.rnd_valid, ifa.rnd_fail); end
        // lfsr must restart at 000 and the pointer at 0, so requester 3 is found by wrap search
        ifa.limit = 12'hFFF;
        ifa.req   = 4'b1000;
        tick();
        n_cmp++; if (ifa.gnt !== 4'b1000) begin n_bad++; $display("[TB] FAIL mid_regrant: got %b want 1000", ifa.gnt); end
        tick();
        n_cmp++; if (ifa.rnd_valid !== 1'b1 || ifa.rnd_out !== 3'b000) begin n_bad++; $display("[TB] FAIL mid_lfsr_restart: got valid=%b out=%b want 1 000", ifa.rnd_valid, ifa.rnd_out); end
        ifa.req = 4'b0000;
        tick();
    endtask

    task automatic test_abort;
        ifa.limit = 12'h1C0;
        ifa.req   = 4'b0101;
        tick();
        n_cmp++; if (ifa.gnt !== 4'b0001) begin n_bad++; $display("[TB] FAIL abort_gnt0: got %b want 0001", ifa.gnt); end
        tick();
        n_cmp++; if (ifa.busy !== 1'b1 || ifa.rnd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_drawing: got busy=%b valid=%b want 1 0", ifa.busy, ifa.rnd_valid); end
        ifa.req = 4'b0100;
        tick();
        n_cmp++; if (ifa.gnt !== 4'b0000 || ifa.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_idle: got gnt=%b busy=%b want 0000 0", ifa.gnt, ifa.busy); end
        n_cmp++; if (ifa.rnd_valid !== 1'b0 || ifa.rnd_fail !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_pulse: got valid=%b fail=%b want 0 0", ifa.rnd_valid, ifa.rnd_fail); end
        n_cmp++; if (ifa.rnd_out !== 3'b000) begin n_bad++; $display("[TB] FAIL abort_out_held: got %b want 000", ifa.rnd_out); end
        tick();
        n_cmp++; if (ifa.gnt !== 4'b0100) begin n_bad++; $display("[TB] FAIL abort_gnt2: got %b want 0100", ifa.gnt); end
        tick();
        n_cmp++; if (ifa.rnd_valid !== 1'b1 || ifa.rnd_out !== 3'b110) begin n_bad++; $display("[TB] FAIL abort_gnt2_out: got valid=%b out=%b want 1 110", ifa.rnd_valid, ifa.rnd_out); end
        ifa.req = 4'b0000;
        tick();
        n_cmp++; if (ifa.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_end_busy: got %b want 0", ifa.busy); end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_last_try_accept();
        test_fail_max_tries();
        test_round_robin();
        test_reset_mid_draw();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
